// File: rtl/led_status_sched_pkg.sv
// Shared types and helpers for the status LED scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int BLINK_W = 3;

  // Bits needed to hold 'value'; never returns less than 1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    for (r = 0; v > 0; r++) v = v >> 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/led_status_sched_if.sv
// Requester-side bundle of the status LED scheduler.
interface led_status_sched_if #(
  parameter int N_REQ = 4
);
  // req is a level request; the scheduler acknowledges by raising the one-hot
  // grant, holds it for the whole code and drops it together with the done pulse.
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] blink_cnt;
  logic               led;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               done;

  modport master (output req, blink_cnt, input led, grant, busy, done);
  modport slave  (input req, blink_cnt, output led, grant, busy, done);
endinterface

// File: rtl/led_status_sched_tick_gen.sv
// Time-base prescaler: one-cycle tick every CYC_PER_TICK cycles, sync clear.
module led_tick_gen
  import led_sched_pkg::*;
#(
  parameter int CYC_PER_TICK = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = clogb2(CYC_PER_TICK - 1);
  localparam logic [CW-1:0] LAST = CW'(CYC_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_status_sched.sv
// Plays one requester's blink code on the status LED; fixed priority, lowest index wins.
// Optional LED_SCHED_HEARTBEAT_EN: 1 Hz heartbeat on the LED while idle.
module led_status_sched
  import led_sched_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 50000000,
  parameter int P_TICK_HZ     = 10,
  parameter int N_REQ         = 4,
  parameter int P_ON_TICKS    = 2,
  parameter int P_OFF_TICKS   = 2,
  parameter int P_GAP_TICKS   = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  led_status_sched_if.slave bus,
  output state_e dbg_state
);

  localparam int CYC_PER_TICK = P_CLK_FREQ_HZ / P_TICK_HZ;
  localparam int MAX_ONOFF    = (P_ON_TICKS > P_OFF_TICKS) ? P_ON_TICKS : P_OFF_TICKS;
  localparam int MAX_TICKS    = (MAX_ONOFF > P_GAP_TICKS) ? MAX_ONOFF : P_GAP_TICKS;
  localparam int PH_W         = clogb2(MAX_TICKS);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(P_ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(P_OFF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(P_GAP_TICKS - 1);

  state_e               state;
  logic                 led_q;
  logic [N_REQ-1:0]     grant_q;
  logic                 busy_q;
  logic                 done_q;
  logic [PH_W-1:0]      phase_cnt;
  logic [BLINK_W-1:0]   blinks_left;

  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     win_oh;
  logic [BLINK_W-1:0]   win_cnt;
  logic                 start;
  logic                 tick;

  always_comb begin
    elig    = '0;
    win_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req[i] && (bus.blink_cnt[BLINK_W*i +: BLINK_W] != '0);
    end
    // Isolate the lowest set bit: lowest index has priority.
    win_oh = elig & (~elig + 1'b1);
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) win_cnt = bus.blink_cnt[BLINK_W*i +: BLINK_W];
    end
  end

  assign start = (state == ST_IDLE) && (elig != '0);

  led_tick_gen #(
    .CYC_PER_TICK (CYC_PER_TICK)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .tick  (tick)
  );

`ifdef LED_SCHED_HEARTBEAT_EN
  localparam int HB_HALF = P_CLK_FREQ_HZ / 2;
  localparam int HB_W    = clogb2(HB_HALF - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);

  logic [HB_W-1:0] hb_cnt;
  logic            hb_tick;

  // Free-running: sequences do not disturb the heartbeat phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign hb_tick = (hb_cnt == HB_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      led_q       <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_cnt   <= '0;
      blinks_left <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_ON;
            led_q       <= 1'b1;
            busy_q      <= 1'b1;
            grant_q     <= win_oh;
            blinks_left <= win_cnt;
            phase_cnt   <= '0;
          end
`ifdef LED_SCHED_HEARTBEAT_EN
          else if (hb_tick) begin
            led_q <= ~led_q;
          end
`endif
        end
        ST_ON: begin
          if (tick) begin
            if (phase_cnt == ON_LAST) begin
              state     <= ST_OFF;
              led_q     <= 1'b0;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (phase_cnt == OFF_LAST) begin
              phase_cnt   <= '0;
              blinks_left <= blinks_left - 1'b1;
              if (blinks_left != BLINK_W'(1)) begin
                state <= ST_ON;
                led_q <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (phase_cnt == GAP_LAST) begin
              state     <= ST_IDLE;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              grant_q   <= '0;
              led_q     <= 1'b0;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.led   = led_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign dbg_state = state;

endmodule
